spad_fill_ctrl: RTL

Loader stage directly upstream of the PE scratchpad SRAM. Accepts a stream of words from the GLB/NoC over a valid/ready handshake and converts it into SPad write cycles: chip enable, write enable, write address, write data. Loads a programmed number of words starting at a programmed base address, with circular address wrap at DEPTH, and reports completion to the PE controller.

---
 rtl/spad_fill_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/spad_fill_ctrl.sv
// Scratchpad fill controller: turns a valid/ready word stream into
// SPad write cycles from a base address, wrapping circularly at DEPTH.
module spad_fill_ctrl #(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 96,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LEN_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  spad_chip_en,
  output logic                  spad_write_en,
  output logic [ADDR_WIDTH-1:0] spad_write_addr,
  output logic [DATA_WIDTH-1:0] spad_write_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [LEN_WIDTH-1:0]  words_written
);

  localparam logic [ADDR_WIDTH:0] LP_DEPTH_A =
    (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [LEN_WIDTH-1:0] LP_LEN_MAX =
    LEN_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LP_LAST =
    ADDR_WIDTH'(DEPTH - 1);
  localparam logic [LEN_WIDTH-1:0] LP_ONE =
    LEN_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [LEN_WIDTH-1:0]    r_rem;
  logic                    r_in_ready;
  logic                    r_ce;
  logic                    r_we;
  logic [ADDR_WIDTH-1:0]   r_waddr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_err;
  logic [LEN_WIDTH-1:0]    r_ww;

  logic                    w_hs;
  logic                    w_bad;
  logic [ADDR_WIDTH-1:0]   w_next_addr;

  assign w_hs  = in_valid & r_in_ready;
  assign w_bad = ({1'b0, base_addr} >= LP_DEPTH_A)
               | (length > LP_LEN_MAX);
  assign w_next_addr = (r_addr == LP_LAST)
                     ? '0 : r_addr + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_rem      <= '0;
      r_in_ready <= 1'b0;
      r_ce       <= 1'b0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_ww       <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_ce   <= 1'b0;
      r_we   <= 1'b0;
      // A completed handshake is always committed, even when aborting.
      if (w_hs) begin
        r_ce    <= 1'b1;
        r_we    <= 1'b1;
        r_waddr <= r_addr;
        r_wdata <= in_data;
        r_addr  <= w_next_addr;
        r_rem   <= r_rem - 1'b1;
        r_ww    <= r_ww + 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_bad) begin
              r_err <= 1'b1;
            end else if (length == '0) begin
              r_state <= S_DONE;
              r_busy  <= 1'b1;
              r_done  <= 1'b1;
              r_ww    <= '0;
            end else begin
              r_state    <= S_FILL;
              r_addr     <= base_addr;
              r_rem      <= length;
              r_ww       <= '0;
              r_busy     <= 1'b1;
              r_in_ready <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (abort) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b0;
          end else if (w_hs && r_rem == LP_ONE) begin
            r_state    <= S_FLUSH;
            r_in_ready <= 1'b0;
          end
        end
        S_FLUSH: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready        = r_in_ready;
  assign spad_chip_en    = r_ce;
  assign spad_write_en   = r_we;
  assign spad_write_addr = r_waddr;
  assign spad_write_data = r_wdata;
  assign busy            = r_busy;
  assign done            = r_done;
  assign err             = r_err;
  assign words_written   = r_ww;

endmodule
